// File: rtl/pp_row_reader.sv
// Drains one buffered row per burst from the preprocess FIFO and
// re-emits it as a valid/ready pixel stream with row/frame markers.
module pp_row_reader #(
  parameter int DATA_WIDTH   = 12,
  parameter int FILL_WIDTH   = 11,
  parameter int LINE_WIDTH   = 640,
  parameter int FRAME_HEIGHT = 480,
  parameter int OBUF_DEPTH   = 4
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_enable,
  input  logic                  i_flush,
  output logic                  o_rd,
  input  logic [DATA_WIDTH-1:0] i_data,
  input  logic                  i_valid,
  input  logic [FILL_WIDTH-1:0] i_fill,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic                  o_valid,
  input  logic                  i_ready,
  output logic                  o_sol,
  output logic                  o_eol,
  output logic                  o_sof,
  output logic                  o_eof,
  output logic [9:0]            o_col,
  output logic [8:0]            o_row,
  output logic                  o_underrun,
  output logic                  o_busy
);

  localparam int IW = $clog2(LINE_WIDTH + 1);
  localparam int AW = $clog2(OBUF_DEPTH);
  localparam logic [IW-1:0] LW_I = IW'(LINE_WIDTH);

  typedef enum logic [1:0] {
    IDLE,
    WAIT_ROW,
    BURST,
    DRAIN
  } state_t;

  typedef struct packed {
    logic [DATA_WIDTH-1:0] data;
    logic [9:0]            col;
    logic [8:0]            row;
  } pix_t;

  state_t        state, state_n;
  logic [IW-1:0] issued;
  logic [IW-1:0] ret_cnt;
  logic [8:0]    row_cnt;
  logic          pend;
  logic          rd_n;
  logic          push, pop, miss;
  logic          empty, go_row, row_done, can_issue;
  logic [AW:0]   wptr, rptr, occ;
  logic [AW+1:0] pending;
  pix_t          mem [OBUF_DEPTH];
  pix_t          head;

  assign occ   = wptr - rptr;
  assign empty = (occ == '0);
  assign push  = pend && i_valid;
  assign miss  = pend && !i_valid;
  assign pop   = !empty && i_ready;

  // Credit counts buffered pixels plus both read stages still in flight.
  assign pending   = {1'b0, occ} + (AW+2)'(o_rd) + (AW+2)'(pend);
  assign can_issue = (issued < LW_I) &&
                     (pending < (AW+2)'(OBUF_DEPTH));
  assign go_row    = i_enable &&
                     (i_fill >= FILL_WIDTH'(LINE_WIDTH));
  assign row_done  = (ret_cnt == LW_I) && empty &&
                     !o_rd && !pend;

  always_comb begin
    state_n = state;
    rd_n    = 1'b0;
    unique case (state)
      IDLE: begin
        if (i_enable) state_n = WAIT_ROW;
      end
      WAIT_ROW: begin
        if (!i_enable) begin
          state_n = IDLE;
        end else if (go_row) begin
          state_n = BURST;
          rd_n    = can_issue;
        end
      end
      BURST: begin
        rd_n = can_issue;
        if (issued == LW_I) state_n = DRAIN;
      end
      DRAIN: begin
        // Late underruns may still need a re-read here.
        rd_n = can_issue;
        if (row_done) state_n = WAIT_ROW;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst || i_flush) begin
      state      <= IDLE;
      o_rd       <= 1'b0;
      pend       <= 1'b0;
      o_underrun <= 1'b0;
      issued     <= '0;
      ret_cnt    <= '0;
      row_cnt    <= '0;
      wptr       <= '0;
      rptr       <= '0;
    end else begin
      state      <= state_n;
      o_rd       <= rd_n;
      pend       <= o_rd;
      o_underrun <= miss;
      if (state == DRAIN && row_done) begin
        issued  <= '0;
        ret_cnt <= '0;
        if (row_cnt == 9'(FRAME_HEIGHT - 1)) row_cnt <= '0;
        else row_cnt <= row_cnt + 9'd1;
      end else begin
        issued <= issued + IW'(rd_n) - IW'(miss);
        if (push) ret_cnt <= ret_cnt + IW'(1);
      end
      if (push) wptr <= wptr + (AW+1)'(1);
      if (pop) rptr <= rptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge i_clk) begin
    if (push) mem[wptr[AW-1:0]] <= '{i_data, 10'(ret_cnt), row_cnt};
  end

  assign head    = mem[rptr[AW-1:0]];
  assign o_valid = !empty;
  assign o_data  = o_valid ? head.data : '0;
  assign o_col   = o_valid ? head.col : '0;
  assign o_row   = o_valid ? head.row : '0;
  assign o_sol   = o_valid && (head.col == 10'd0);
  assign o_eol   = o_valid && (head.col == 10'(LINE_WIDTH - 1));
  assign o_sof   = o_sol && (head.row == 9'd0);
  assign o_eof   = o_eol && (head.row == 9'(FRAME_HEIGHT - 1));
  assign o_busy  = (state != IDLE);

endmodule
